vrms_event_detector: RTL

- Downstream consumer of the RMS voltage stage; takes one 24-bit Vrms result per averaging window and classifies the supply as normal, sag, swell or interruption.
- Applies entry confirmation (N consecutive windows) and exit hysteresis.
- Tracks event duration (in windows) and the extreme Vrms reached.
- Emits a one-cycle summary pulse per completed event to the compensation controller.

---
 rtl/vrms_event_detector.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vrms_event_detector.sv
// Supply event classifier: turns per-window Vrms results into sag/swell/interruption
// flags with entry confirmation, exit hysteresis and per-event duration/extreme summary.
module vrms_event_detector #(
  parameter logic [23:0] INT_TH   = 24'd400000,
  parameter logic [23:0] SAG_TH   = 24'd3600000,
  parameter logic [23:0] SWELL_TH = 24'd4400000,
  parameter logic [23:0] HYST     = 24'd80000,
  parameter int unsigned CONFIRM  = 2,
  parameter int unsigned DUR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      vrms_in,
  input  logic             vrms_valid,
  output logic             sag,
  output logic             swell,
  output logic             intr,
  output logic             event_done,
  output logic [1:0]       event_type,
  output logic [DUR_W-1:0] event_dur,
  output logic [23:0]      event_ext,
  output logic [15:0]      event_count
);

  localparam int unsigned VW  = 24;
  localparam int unsigned VW1 = VW + 1;
  localparam int unsigned CW  = 4;

  localparam logic [VW:0]   SAG_EXIT   = VW1'(SAG_TH) + VW1'(HYST);
  localparam logic [VW:0]   INT_EXIT   = VW1'(INT_TH) + VW1'(HYST);
  localparam logic [VW-1:0] SWELL_EXIT = SWELL_TH - HYST;

  typedef enum logic [2:0] {S_NORMAL, S_PEND, S_SAG, S_SWELL, S_INT} state_t;
  typedef enum logic [1:0] {C_NORM = 2'd0, C_SAG = 2'd1, C_SWELL = 2'd2, C_INT = 2'd3} cls_t;

  state_t           state;
  cls_t             cand;
  cls_t             cls;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [DUR_W-1:0] dur;
  logic [DUR_W-1:0] dur_inc;
  logic [VW-1:0]    ext;
  logic [VW-1:0]    ext_min;
  logic [VW-1:0]    ext_max;

  // Entry classification of the incoming window plus saturating/extreme helpers
  always_comb begin
    cls = C_NORM;
    if (vrms_in < INT_TH)        cls = C_INT;
    else if (vrms_in < SAG_TH)   cls = C_SAG;
    else if (vrms_in > SWELL_TH) cls = C_SWELL;
    ext_min = (vrms_in < ext) ? vrms_in : ext;
    ext_max = (vrms_in > ext) ? vrms_in : ext;
    dur_inc = (dur == '1) ? dur : dur + DUR_W'(1);
    cnt_inc = cnt + CW'(1);
  end

  function automatic state_t event_state(input cls_t c);
    case (c)
      C_SAG:   return S_SAG;
      C_SWELL: return S_SWELL;
      default: return S_INT;
    endcase
  endfunction

  function automatic logic [1:0] type_of(input state_t s);
    case (s)
      S_SAG:   return 2'd1;
      S_SWELL: return 2'd2;
      S_INT:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // State and flags always move together so the flags stay one-hot-or-zero
  task automatic go(input state_t s);
    state <= s;
    sag   <= (s == S_SAG);
    swell <= (s == S_SWELL);
    intr  <= (s == S_INT);
  endtask

  task automatic restart();
    cand <= cls;
    cnt  <= CW'(1);
    ext  <= vrms_in;
    dur  <= DUR_W'(1);
    if (cls == C_NORM)      go(S_NORMAL);
    else if (CONFIRM == 1)  go(event_state(cls));
    else                    go(S_PEND);
  endtask

  task automatic finish_event();
    event_done  <= 1'b1;
    event_type  <= type_of(state);
    event_dur   <= dur;
    event_ext   <= ext;
    event_count <= (event_count == 16'hFFFF) ? event_count : event_count + 16'd1;
    restart();
  endtask

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_NORMAL;
      cand        <= C_NORM;
      cnt         <= '0;
      dur         <= '0;
      ext         <= '0;
      sag         <= 1'b0;
      swell       <= 1'b0;
      intr        <= 1'b0;
      event_done  <= 1'b0;
      event_type  <= 2'd0;
      event_dur   <= '0;
      event_ext   <= '0;
      event_count <= '0;
    end else begin
      event_done <= 1'b0;
      if (vrms_valid) begin
        case (state)
          S_NORMAL: restart();
          S_PEND: begin
            if (cls == cand) begin
              cnt <= cnt_inc;
              ext <= (cand == C_SWELL) ? ext_max : ext_min;
              if (cnt_inc == CW'(CONFIRM)) begin
                go(event_state(cand));
                dur <= DUR_W'(CONFIRM);
              end
            end else begin
              restart();
            end
          end
          S_SAG: begin
            if (cls == C_INT) begin
              go(S_INT);
              dur <= dur_inc;
              ext <= ext_min;
            end else if ({1'b0, vrms_in} >= SAG_EXIT) begin
              finish_event();
            end else begin
              dur <= dur_inc;
              ext <= ext_min;
            end
          end
          S_INT: begin
            if ({1'b0, vrms_in} >= INT_EXIT) begin
              finish_event();
            end else begin
              dur <= dur_inc;
              ext <= ext_min;
            end
          end
          S_SWELL: begin
            if (vrms_in <= SWELL_EXIT) begin
              finish_event();
            end else begin
              dur <= dur_inc;
              ext <= ext_max;
            end
          end
          default: go(S_NORMAL);
        endcase
      end
    end
  end

endmodule
